uart_rx_deser: RTL and testbench
================================

UART_RX_DESER -- requirements
Module: uart_rx_deser

Interface
REQ-001: The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002: Parameter DIV_W, default 16, SHALL set the width of the baud divisor input.
REQ-003: Port i_clk  input  1  system clock; all state updates on its rising edge.
REQ-004: Port i_rst  input  1  synchronous active-high reset.
REQ-005: Port i_baud_div  input  DIV_W  clocks per bit minus one; minimum legal value 3.
REQ-006: Port i_rx_en  input  1  receiver enable.
REQ-007: Port i_rxd  input  1  asynchronous serial line, idle high.
REQ-008: Port o_data  output  8  received byte.
REQ-009: Port o_valid  output  1  o_data holds an unconsumed byte.
REQ-010: Port i_ready  input  1  downstream RX FIFO accepts the byte (push-not-full).
REQ-011: Port o_frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-012: Port o_parity_err  output  1  one-cycle pulse on a parity mismatch; tied 0 without the parity feature.
REQ-013: Port o_overrun  output  1  one-cycle pulse when a byte is dropped.
REQ-014: Port o_busy  output  1  high whenever the state is not IDLE.

Function
REQ-015: i_rxd SHALL pass through a 2-flop synchronizer; "line" below means the synchronizer output, plus one delayed copy for edge detection.
REQ-016: States SHALL be IDLE, START, DATA, PARITY (only with the parity feature) and STOP.
REQ-017: In IDLE, a 1-to-0 line transition with i_rx_en=1 SHALL move the block to START, latch i_baud_div into a divisor register, and clear the bit counter.
REQ-018: In START, the line SHALL be sampled after floor((div+1)/2) clocks. If it reads 1, the block returns to IDLE with no output (glitch reject); if 0, it moves to DATA.
REQ-019: In DATA, the line SHALL be sampled every div+1 clocks, LSB first. After 8 samples the block moves to PARITY (feature on) or STOP (feature off).
REQ-020: PARITY and STOP SHALL each sample one bit after div+1 clocks. After the STOP sample the block returns to IDLE immediately, mid stop bit.
REQ-021: A STOP sample of 0 SHALL pulse o_frame_err and discard the byte.
REQ-022: A good frame SHALL be delivered on the cycle after the STOP sample: o_data is loaded and o_valid is set to 1.
REQ-023: A transfer SHALL occur on any cycle with o_valid=1 and i_ready=1. o_valid clears on the next cycle unless a new byte is delivered in that same cycle; in that case o_valid stays 1 and o_data takes the new byte.
REQ-024: If a good frame completes while o_valid=1 and i_ready=0, the block SHALL pulse o_overrun, drop the new byte, and leave o_data unchanged.
REQ-025: i_rx_en=0 in any state SHALL force IDLE on the next cycle with no output and no error pulse. A byte already held in o_data is unaffected.
REQ-026: Changes to i_baud_div during a frame SHALL have no effect until the next start edge.

Reset
REQ-027: On i_rst=1 the block SHALL enter IDLE and clear o_valid, o_data, o_frame_err, o_parity_err, o_overrun, o_busy and all counters to 0; both synchronizer flops and the edge-detect flop are set to 1.
REQ-028: A reset asserted mid-frame SHALL abort the frame with no delivery and no error pulse.

Configuration
REQ-029: Macro AMBER_UART_PARITY_EN defined: the PARITY state is present, even parity is checked over the data bits, and a mismatch pulses o_parity_err and discards the byte. Stop-bit checking still applies.
REQ-030: Macro AMBER_UART_PARITY_EN undefined: there is no PARITY state, each frame is 10 bits, and o_parity_err is constant 0.

Verification
REQ-031: div=3, i_ready=1, line sends 0xA5 with stop=1 -> o_valid high for exactly 1 cycle with o_data=0xA5; no error pulses.
REQ-032: div=3, line low for 1 clock then high -> block returns to IDLE; o_valid stays 0 and o_busy falls within 3 cycles.
REQ-033: div=3, byte 0x3C with stop bit 0 -> o_frame_err pulses once; o_valid stays 0.
REQ-034: div=3, i_ready=0, bytes 0x11 then 0x22 -> o_data=0x11 held; o_overrun pulses once at the end of the 0x22 frame; raising i_ready then gives one transfer of 0x11.
REQ-035: div=7, i_rst pulsed during DATA bit 4, then 0x5A sent -> no output from the aborted frame; 0x5A delivered correctly.
REQ-036: AMBER_UART_PARITY_EN defined, byte 0x01 with parity bit 0 -> o_parity_err pulses once; o_valid stays 0. Same byte with parity bit 1 -> 0x01 delivered.

Source files
------------

// File: rtl/uart_rx_deser.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_deser
// Brief    : 8-bit UART receiver with a 2-flop input synchronizer and a
//            one-byte valid/ready output stage. Build with
//            AMBER_UART_PARITY_EN defined to add even-parity checking.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_deser #(
    parameter int DIV_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [DIV_W-1:0] i_baud_div,
    input  logic             i_rx_en,
    input  logic             i_rxd,
    output logic [7:0]       o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_frame_err,
    output logic             o_parity_err,
    output logic             o_overrun,
    output logic             o_busy
);

`ifdef AMBER_UART_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd4
    } state_t;
`endif

    state_t             r_state;
    state_t             w_state_nx;
    logic               r_sync1;
    logic               r_sync2;
    logic               r_line_d;
    logic [DIV_W-1:0]   r_div;
    logic [DIV_W-1:0]   r_cnt;
    logic [2:0]         r_bit_cnt;
    logic [7:0]         r_shift;
    logic [7:0]         r_data;
    logic               r_valid;
    logic               r_ferr;
    logic               r_ovr;

    logic               w_line;
    logic               w_fall;
    logic [DIV_W:0]     w_div_p1;
    logic [DIV_W-1:0]   w_half_m1;
    logic               w_half_tick;
    logic               w_tick;
    logic               w_par_ok;
    logic               w_start;
    logic               w_cnt_clr;
    logic               w_shift;
    logic               w_good;
    logic               w_ferr;
    logic               w_perr;

    assign w_line      = r_sync2;
    assign w_fall      = r_line_d & ~r_sync2;
    assign w_div_p1    = {1'b0, r_div} + {{DIV_W{1'b0}}, 1'b1};
    assign w_half_m1   = w_div_p1[DIV_W:1] - {{(DIV_W-1){1'b0}}, 1'b1};
    assign w_half_tick = (r_cnt == w_half_m1);
    assign w_tick      = (r_cnt == r_div);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_line_d <= 1'b1;
        end else begin
            r_sync1  <= i_rxd;
            r_sync2  <= r_sync1;
            r_line_d <= r_sync2;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_start    = 1'b0;
        w_cnt_clr  = 1'b0;
        w_shift    = 1'b0;
        w_good     = 1'b0;
        w_ferr     = 1'b0;
        w_perr     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    w_state_nx = S_START;
                    w_start    = 1'b1;
                end
            end
            S_START: begin
                if (w_half_tick) begin
                    w_cnt_clr  = 1'b1;
                    w_state_nx = w_line ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_cnt_clr = 1'b1;
                    w_shift   = 1'b1;
                    if (r_bit_cnt == 3'd7) begin
`ifdef AMBER_UART_PARITY_EN
                        w_state_nx = S_PARITY;
`else
                        w_state_nx = S_STOP;
`endif
                    end
                end
            end
`ifdef AMBER_UART_PARITY_EN
            S_PARITY: begin
                if (w_tick) begin
                    w_cnt_clr  = 1'b1;
                    w_state_nx = S_STOP;
                    w_perr     = (w_line != ^r_shift);
                end
            end
`endif
            S_STOP: begin
                if (w_tick) begin
                    w_cnt_clr  = 1'b1;
                    w_state_nx = S_IDLE;
                    if (!w_line) begin
                        w_ferr = 1'b1;
                    end else if (w_par_ok) begin
                        w_good = 1'b1;
                    end
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
        // Disable wins over everything, including a frame completing this cycle.
        if (!i_rx_en) begin
            w_state_nx = S_IDLE;
            w_start    = 1'b0;
            w_good     = 1'b0;
            w_ferr     = 1'b0;
            w_perr     = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div     <= '0;
            r_cnt     <= '0;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'd0;
        end else begin
            if (r_state == S_IDLE || w_cnt_clr) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + {{(DIV_W-1){1'b0}}, 1'b1};
            end
            if (w_start) begin
                r_div     <= i_baud_div;
                r_bit_cnt <= 3'd0;
            end else if (w_shift) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_shift) begin
                r_shift <= {w_line, r_shift[7:1]};
            end
        end
    end

`ifdef AMBER_UART_PARITY_EN
    logic r_par_bad;
    logic r_perr;

    // Parity result is held until the stop bit decides whether to deliver.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_par_bad <= 1'b0;
            r_perr    <= 1'b0;
        end else begin
            r_perr <= w_perr;
            if (w_start) begin
                r_par_bad <= 1'b0;
            end else if (w_perr) begin
                r_par_bad <= 1'b1;
            end
        end
    end
    assign w_par_ok     = ~r_par_bad;
    assign o_parity_err = r_perr;
`else
    assign w_par_ok     = 1'b1;
    assign o_parity_err = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data  <= 8'd0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_ferr <= w_ferr;
            r_ovr  <= 1'b0;
            if (w_good) begin
                if (!r_valid || i_ready) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_ovr <= 1'b1;
                end
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_data      = r_data;
    assign o_valid     = r_valid;
    assign o_frame_err = r_ferr;
    assign o_overrun   = r_ovr;
    assign o_busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_deser.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_deser
// Brief    : Randomized self-checking bench for uart_rx_deser against a
//            frame-level scoreboard model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_deser;
    localparam int DIV_W = 16;

    logic             i_clk = 1'b0;
    logic             i_rst = 1'b1;
    logic [DIV_W-1:0] i_baud_div = 16'd3;
    logic             i_rx_en = 1'b1;
    logic             i_rxd = 1'b1;
    logic [7:0]       o_data;
    logic             o_valid;
    logic             i_ready = 1'b1;
    logic             o_frame_err;
    logic             o_parity_err;
    logic             o_overrun;
    logic             o_busy;

    always #5 i_clk = ~i_clk;

    uart_rx_deser #(.DIV_W(DIV_W)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_baud_div   (i_baud_div),
        .i_rx_en      (i_rx_en),
        .i_rxd        (i_rxd),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_frame_err  (o_frame_err),
        .o_parity_err (o_parity_err),
        .o_overrun    (o_overrun),
        .o_busy       (o_busy)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int n_ferr = 0, n_perr = 0, n_ovr = 0, n_vcyc = 0;
    int e_ferr = 0, e_perr = 0, e_ovr = 0;

    // Observe outputs on the falling edge, between active edges.
    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (o_valid) n_vcyc++;
            if (o_valid && i_ready) got_q.push_back(o_data);
            if (o_frame_err) n_ferr++;
            if (o_parity_err) n_perr++;
            if (o_overrun) n_ovr++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive_bit(input logic v, input int div);
        i_rxd = v;
        repeat (div + 1) tick();
    endtask

    // Divisor is scrambled after the start bit; the frame must keep its latched value.
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b, input int div);
        i_baud_div = div[DIV_W-1:0];
        drive_bit(1'b0, div);
        i_baud_div = DIV_W'($urandom_range(3, 200));
        for (int i = 0; i < 8; i++) drive_bit(d[i], div);
`ifdef AMBER_UART_PARITY_EN
        drive_bit(par_b, div);
`endif
        drive_bit(stop_b, div);
        i_rxd = 1'b1;
        repeat (2 * (div + 1)) tick();
    endtask

    // Frame-level reference: what a receiver with i_ready=1 must report.
    task automatic model_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
        logic par_bad;
        par_bad = 1'b0;
`ifdef AMBER_UART_PARITY_EN
        par_bad = (par_b != (^d));
        if (par_bad) e_perr++;
`endif
        if (!stop_b) e_ferr++;
        else if (!par_bad) exp_q.push_back(d);
    endtask

    task automatic sb_check(input string tag);
        chk({tag, "_xfer_count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0)
            chk({tag, "_data"}, got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
        chk({tag, "_frame_err"}, n_ferr, e_ferr);
        chk({tag, "_parity_err"}, n_perr, e_perr);
        chk({tag, "_overrun"}, n_ovr, e_ovr);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic       stop_b, par_b;
        int         div, v0, k;
        bit         seen;

        repeat (3) tick();
        chk("rst_valid", o_valid, 0);
        chk("rst_data", o_data, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_errs", {o_frame_err, o_parity_err, o_overrun}, 0);
        i_rst = 1'b0;
        tick();

        // Clean 0xA5 frame at the minimum divisor
        v0 = n_vcyc;
        send_frame(8'hA5, 1'b1, ^8'hA5, 3);
        model_frame(8'hA5, 1'b1, ^8'hA5);
        sb_check("a5");
        chk("a5_valid_cycles", n_vcyc - v0, 1);

        // One-clock low glitch must be rejected
        i_baud_div = 16'd3;
        i_rxd = 1'b0;
        tick();
        i_rxd = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (o_busy) seen = 1'b1;
            else tick();
        end
        chk("glitch_busy_rise", seen, 1);
        k = 0;
        while (o_busy && k < 10) begin
            tick();
            k++;
        end
        chk("glitch_busy_fall_le3", (k <= 3), 1);
        repeat (10) tick();
        sb_check("glitch");

        // Bad stop bit
        send_frame(8'h3C, 1'b0, ^8'h3C, 3);
        model_frame(8'h3C, 1'b0, ^8'h3C);
        sb_check("ferr");

        // Overrun with downstream stalled
        i_ready = 1'b0;
        send_frame(8'h11, 1'b1, ^8'h11, 3);
        send_frame(8'h22, 1'b1, ^8'h22, 3);
        e_ovr++;
        chk("ovr_valid_held", o_valid, 1);
        chk("ovr_data_held", o_data, 8'h11);
        i_ready = 1'b1;
        repeat (3) tick();
        exp_q.push_back(8'h11);
        sb_check("ovr");
        chk("ovr_valid_clear", o_valid, 0);

        // Reset in the middle of DATA bit 4, then a clean frame
        div = 7;
        i_baud_div = 16'd7;
        d = 8'($urandom);
        drive_bit(1'b0, div);
        for (int i = 0; i < 4; i++) drive_bit(d[i], div);
        i_rxd = d[4];
        repeat (4) tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        i_rxd = 1'b1;
        chk("midrst_busy", o_busy, 0);
        chk("midrst_valid", o_valid, 0);
        repeat (20) tick();
        send_frame(8'h5A, 1'b1, ^8'h5A, 7);
        model_frame(8'h5A, 1'b1, ^8'h5A);
        sb_check("midrst");

        // Receiver disabled mid-frame: abort silently
        div = 4;
        i_baud_div = 16'd4;
        d = 8'($urandom);
        drive_bit(1'b0, div);
        for (int i = 0; i < 3; i++) drive_bit(d[i], div);
        i_rx_en = 1'b0;
        tick();
        chk("rxen_busy", o_busy, 0);
        for (int i = 3; i < 8; i++) drive_bit(d[i], div);
        drive_bit(1'b1, div);
        drive_bit(1'b1, div);
        i_rx_en = 1'b1;
        tick();
        sb_check("rxen");

`ifdef AMBER_UART_PARITY_EN
        send_frame(8'h01, 1'b1, 1'b0, 3);
        model_frame(8'h01, 1'b1, 1'b0);
        sb_check("par_bad");
        send_frame(8'h01, 1'b1, 1'b1, 3);
        model_frame(8'h01, 1'b1, 1'b1);
        sb_check("par_good");
`endif

        // Randomized frames, divisors, stop and parity bits
        for (int n = 0; n < 16; n++) begin
            d      = 8'($urandom);
            div    = $urandom_range(3, 9);
            stop_b = ($urandom_range(0, 3) != 0);
            par_b  = (^d) ^ ($urandom_range(0, 3) == 0);
            send_frame(d, stop_b, par_b, div);
            model_frame(d, stop_b, par_b);
            sb_check("rand");
        end
        chk("end_busy", o_busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
